// File: rtl/sampler_pkg.sv
// sampler_pkg: shared types and helpers for the two-track note sampler.
//   NOTE_W_DEF   default note vector width (one bit per key q..o)
//   STEPS_DEF    default number of notes stored per track
//   LEN_W        width of track lengths and the playback step index
//   state_t      scheduler FSM state encoding (IDLE/REC/PLAY)
//   NOTE_SILENCE all-keys-off note value
//   is_onehot()  true when exactly one key is down
package sampler_pkg;

  localparam int NOTE_W_DEF = 9;
  localparam int STEPS_DEF  = 10;
  localparam int LEN_W      = $clog2(STEPS_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REC  = 2'b01,
    ST_PLAY = 2'b10
  } state_t;

  localparam logic [NOTE_W_DEF-1:0] NOTE_SILENCE = '0;

  // Callers zero-extend their note vector to 32 bits.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: terminal-count strobe generator used to time playback steps.
//   clk      system clock
//   reset    asynchronous active-low reset
//   restart  synchronous restart; holds the count at zero while high
//   strobe   high for one cycle on every TICK_DIV-th cycle after restart drops
module tick_gen #(
  parameter int TICK_DIV = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic strobe
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign strobe = !restart && (cnt == LAST);

endmodule

// File: rtl/sample_scheduler.sv
// sample_scheduler: record/playback controller for the two-track note sampler.
// Captures one-hot key presses into one of two tracks, plays one or both
// tracks back at a fixed step rate, and arbitrates the single note output.
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   note_in   live key levels from the keyboard tracker
//   rec_req   per-track pulse: start/stop recording track k
//   play_req  per-track pulse: start playback of track k
//   clear     pulse: abort activity and erase both tracks
//   note_out  registered note to the LED/audio sink
//   state_o   FSM state (00 IDLE, 01 REC, 10 PLAY), also the debug view
//   busy      high whenever the FSM is not IDLE
//   len0/len1 stored length of each track
//
// Request pulses carry no handshake: each is a one-cycle strobe acted on in
// the cycle it is seen (or ignored if the current state does not accept it);
// there is no ready/backpressure path back to the requester.
//
// Build option: define LIVE_MIX_EN to OR valid live keys into the playback
// output. Undefined (default), live input has no effect during playback.
module sample_scheduler
  import sampler_pkg::*;
#(
  parameter int NOTE_W   = NOTE_W_DEF,
  parameter int STEPS    = STEPS_DEF,
  parameter int TICK_DIV = 12500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [1:0]        rec_req,
  input  logic [1:0]        play_req,
  input  logic              clear,
  output logic [NOTE_W-1:0] note_out,
  output logic [1:0]        state_o,
  output logic              busy,
  output logic [LEN_W-1:0]  len0,
  output logic [LEN_W-1:0]  len1
);

  localparam logic [NOTE_W-1:0] SILENCE   = NOTE_W'(NOTE_SILENCE);
  localparam logic [LEN_W-1:0]  LAST_SLOT = LEN_W'(STEPS - 1);

  state_t            state_q, state_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [NOTE_W-1:0] prev_note;
  logic [LEN_W-1:0]  len_q [2];
  logic [LEN_W-1:0]  len_d [2];
  logic              rec_trk_q, rec_trk_d;
  logic [1:0]        active_q, active_d;
  logic [LEN_W-1:0]  step_q, step_d;
  logic [NOTE_W-1:0] mem [2][STEPS];

  logic              note_valid;
  logic              new_press;
  logic [NOTE_W-1:0] live_note;
  logic [NOTE_W-1:0] play_note;
  logic [NOTE_W-1:0] play_mix;
  logic [LEN_W-1:0]  cur_len;
  logic [LEN_W-1:0]  len_a, len_b, max_len;
  logic [1:0]        play_set;
  logic              wr_en;
  logic              tick_restart;
  logic              tick_strobe;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (tick_restart),
    .strobe  (tick_strobe)
  );

  // Live-input qualification. prev_note tracks raw levels, so a key held
  // across a state change is not seen as a fresh press.
  always_comb begin
    note_valid = is_onehot(32'(note_in));
    live_note  = note_valid ? note_in : SILENCE;
    new_press  = note_valid && (note_in != prev_note);
  end

  // Playback datapath. A track contributes nothing once the step passes its
  // stored length, so the longer track keeps sounding alone.
  always_comb begin
    play_note = SILENCE;
    for (int k = 0; k < 2; k++) begin
      if (active_q[k] && (step_q < len_q[k])) begin
        play_note = play_note | mem[k][step_q];
      end
    end
    len_a   = active_q[0] ? len_q[0] : '0;
    len_b   = active_q[1] ? len_q[1] : '0;
    max_len = (len_a > len_b) ? len_a : len_b;
  end

`ifdef LIVE_MIX_EN
  assign play_mix = play_note | live_note;
`else
  assign play_mix = play_note;
`endif

  assign cur_len  = len_q[rec_trk_q];
  assign play_set = play_req & {len_q[1] != '0, len_q[0] != '0};

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    note_d       = live_note;
    len_d[0]     = len_q[0];
    len_d[1]     = len_q[1];
    rec_trk_d    = rec_trk_q;
    active_d     = active_q;
    step_d       = step_q;
    wr_en        = 1'b0;
    tick_restart = (state_q != ST_PLAY);

    if (clear) begin
      state_d  = ST_IDLE;
      note_d   = SILENCE;
      len_d[0] = '0;
      len_d[1] = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // rec_req wins over play_req; track 0 wins a double record request.
          if (rec_req != 2'b00) begin
            state_d = ST_REC;
            if (rec_req[0]) begin
              rec_trk_d = 1'b0;
              len_d[0]  = '0;
            end else begin
              rec_trk_d = 1'b1;
              len_d[1]  = '0;
            end
          end else if (play_set != 2'b00) begin
            state_d  = ST_PLAY;
            active_d = play_set;
            step_d   = '0;
          end
        end

        ST_REC: begin
          // A press in the same cycle as a stop request is still captured.
          if (new_press) begin
            wr_en              = 1'b1;
            len_d[rec_trk_q]   = cur_len + LEN_W'(1);
            if (cur_len == LAST_SLOT) begin
              state_d = ST_IDLE;
            end
          end
          if (rec_req[rec_trk_q]) begin
            state_d = ST_IDLE;
          end
        end

        ST_PLAY: begin
          if (step_q >= max_len) begin
            state_d = ST_IDLE;
            note_d  = SILENCE;
          end else begin
            note_d = play_mix;
            if (tick_strobe) begin
              step_d = step_q + LEN_W'(1);
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          note_d  = SILENCE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      note_q    <= SILENCE;
      prev_note <= SILENCE;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      rec_trk_q <= 1'b0;
      active_q  <= 2'b00;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      note_q    <= note_d;
      prev_note <= note_in;
      len_q[0]  <= len_d[0];
      len_q[1]  <= len_d[1];
      rec_trk_q <= rec_trk_d;
      active_q  <= active_d;
      step_q    <= step_d;
    end
  end

  // Track storage. Clear leaves contents in place; lengths gate every read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        for (int s = 0; s < STEPS; s++) begin
          mem[k][s] <= SILENCE;
        end
      end
    end else if (wr_en) begin
      mem[rec_trk_q][cur_len] <= note_in;
    end
  end

  assign note_out = note_q;
  assign state_o  = state_q;
  assign busy     = (state_q != ST_IDLE);
  assign len0     = len_q[0];
  assign len1     = len_q[1];

endmodule

// File: tb/tb_sample_scheduler.sv
// tb_sample_scheduler: bench for sample_scheduler with a short step time.
// A cycle-level reference model (track queues, playback position derived
// from elapsed cycles) predicts the registered outputs for each driven cycle;
// a monitor pops and compares them on the falling edge. Directed checks pin
// the scenario results to hand-derived constants.
module tb_sample_scheduler;

  localparam int NW    = 9;
  localparam int STEPS = 10;
  localparam int TDIV  = 4;

  localparam logic [NW-1:0] KQ = 9'b100000000;
  localparam logic [NW-1:0] KW = 9'b010000000;
  localparam logic [NW-1:0] KE = 9'b001000000;
  localparam logic [NW-1:0] KI = 9'b000000010;
  localparam logic [NW-1:0] KO = 9'b000000001;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NW-1:0] note_in = '0;
  logic [1:0]    rec_req = 2'b00;
  logic [1:0]    play_req = 2'b00;
  logic          clear = 1'b0;
  logic [NW-1:0] note_out;
  logic [1:0]    state_o;
  logic          busy;
  logic [3:0]    len0, len1;

  always #5 clk = ~clk;

  sample_scheduler #(
    .NOTE_W   (NW),
    .STEPS    (STEPS),
    .TICK_DIV (TDIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .note_in  (note_in),
    .rec_req  (rec_req),
    .play_req (play_req),
    .clear    (clear),
    .note_out (note_out),
    .state_o  (state_o),
    .busy     (busy),
    .len0     (len0),
    .len1     (len1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // expected {state, note_out, len0, len1} after each driven clock edge
  logic [18:0] exp_q[$];

  // ---------------- reference model ----------------
  int          m_mode;        // 0 idle, 1 recording, 2 playing
  logic [NW-1:0] m_trk[2][$];
  logic [NW-1:0] m_prev;
  logic [NW-1:0] m_out;
  int          m_rec_trk;
  logic [1:0]  m_active;
  int          m_elapsed;

  task automatic model_reset();
    m_mode = 0;
    m_trk[0].delete();
    m_trk[1].delete();
    m_prev = '0;
    m_out = '0;
    m_rec_trk = 0;
    m_active = 2'b00;
    m_elapsed = 0;
  endtask

  task automatic model_cycle(input logic [NW-1:0] ni, input logic [1:0] rr,
                             input logic [1:0] pr, input logic c);
    logic valid, newp;
    logic [NW-1:0] live;
    logic [1:0] pset;
    int step, maxl;
    valid = $onehot(ni);
    newp  = valid && (ni != m_prev);
    live  = valid ? ni : '0;
    if (c) begin
      m_trk[0].delete();
      m_trk[1].delete();
      m_mode = 0;
      m_out = '0;
    end else begin
      case (m_mode)
        0: begin
          m_out = live;
          pset = pr & {m_trk[1].size() != 0, m_trk[0].size() != 0};
          if (rr != 2'b00) begin
            m_rec_trk = rr[0] ? 0 : 1;
            m_trk[m_rec_trk].delete();
            m_mode = 1;
          end else if (pset != 2'b00) begin
            m_active = pset;
            m_elapsed = 0;
            m_mode = 2;
          end
        end
        1: begin
          m_out = live;
          if (newp) m_trk[m_rec_trk].push_back(ni);
          if (m_trk[m_rec_trk].size() == STEPS || rr[m_rec_trk]) m_mode = 0;
        end
        default: begin
          step = m_elapsed / TDIV;
          maxl = 0;
          for (int k = 0; k < 2; k++)
            if (m_active[k] && m_trk[k].size() > maxl) maxl = m_trk[k].size();
          if (step >= maxl) begin
            m_out = '0;
            m_mode = 0;
          end else begin
            m_out = '0;
            for (int k = 0; k < 2; k++)
              if (m_active[k] && step < m_trk[k].size()) m_out = m_out | m_trk[k][step];
`ifdef LIVE_MIX_EN
            m_out = m_out | live;
`endif
            m_elapsed++;
          end
        end
      endcase
    end
    m_prev = ni;
    exp_q.push_back({2'(m_mode), m_out, 4'(m_trk[0].size()), 4'(m_trk[1].size())});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic [NW-1:0] ni, input logic [1:0] rr,
                     input logic [1:0] pr, input logic c);
    @(negedge clk);
    #1;
    note_in  = ni;
    rec_req  = rr;
    play_req = pr;
    clear    = c;
    model_cycle(ni, rr, pr, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 2'b00, 2'b00, 1'b0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [18:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {state_o, note_out, len0, len1};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_model at %0t: got state=%b note=%b len0=%0d len1=%0d expected state=%b note=%b len0=%0d len1=%0d",
                   $time, a[18:17], a[16:8], a[7:4], a[3:0], e[18:17], e[16:8], e[7:4], e[3:0]);
        end
        if (busy !== (state_o != 2'b00)) begin
          n_fail++;
          $display("FAIL busy_flag at %0t: got %b expected %b", $time, busy, state_o != 2'b00);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [NW-1:0] n;
    logic [NW-1:0] last_n;
    int r;

    model_reset();
    #1 reset = 1'b0;
    #1;
    chk("reset_note", 32'(note_out), 0);
    chk("reset_state", 32'(state_o), 0);
    chk("reset_len0", 32'(len0), 0);
    chk("reset_len1", 32'(len1), 0);
    @(negedge clk);
    #2 reset = 1'b1;

    // Record track 0: held-at-entry key and a chord are ignored, a held key counts once.
    cyc(KQ, 2'b01, 2'b00, 1'b0);
    cyc(KQ, 2'b00, 2'b00, 1'b0);
    idle(1);
    cyc(KQ, 2'b00, 2'b00, 1'b0);
    idle(1);
    cyc(KQ | KW, 2'b00, 2'b00, 1'b0);
    idle(1);
    cyc(KW, 2'b00, 2'b00, 1'b0);
    cyc(KW, 2'b00, 2'b00, 1'b0);
    idle(1);
    cyc(KO, 2'b00, 2'b00, 1'b0);
    idle(1);
    cyc('0, 2'b01, 2'b00, 1'b0);
    after_edge();
    chk("rec0_len0", 32'(len0), 3);
    chk("rec0_state", 32'(state_o), 0);

    // Auto-stop on track 1 after ten presses; the eleventh is live only.
    cyc('0, 2'b10, 2'b00, 1'b0);
    for (int i = 0; i < 11; i++) begin
      cyc(NW'(1) << (i % NW), 2'b00, 2'b00, 1'b0);
      if (i == 9) begin
        after_edge();
        chk("autostop_len1", 32'(len1), 10);
        chk("autostop_state", 32'(state_o), 0);
      end
      if (i == 10) begin
        after_edge();
        chk("autostop_live", 32'(note_out), 32'(NW'(1) << 1));
        chk("autostop_len1_hold", 32'(len1), 10);
      end
      idle(1);
    end

    // Track 1 = {e}, then play both.
    cyc('0, 2'b10, 2'b00, 1'b0);
    cyc(KE, 2'b00, 2'b00, 1'b0);
    idle(1);
    cyc('0, 2'b10, 2'b00, 1'b0);
    cyc('0, 2'b00, 2'b11, 1'b0);
    after_edge();
    chk("play_entry_state", 32'(state_o), 2);
    for (int i = 0; i < 13; i++) begin
      idle(1);
      after_edge();
      chk("play_note", 32'(note_out),
          32'((i < 4) ? (KQ | KE) : (i < 8) ? KW : (i < 12) ? KO : '0));
      chk("play_state", 32'(state_o), (i < 12) ? 2 : 0);
    end

    // Conflicts: record beats play, clear aborts recording, empty play is refused.
    cyc('0, 2'b01, 2'b10, 1'b0);
    after_edge();
    chk("conflict_rec_state", 32'(state_o), 1);
    chk("conflict_rec_len0", 32'(len0), 0);
    cyc(KQ, 2'b00, 2'b00, 1'b0);
    idle(1);
    cyc('0, 2'b00, 2'b00, 1'b1);
    after_edge();
    chk("clear_state", 32'(state_o), 0);
    chk("clear_len0", 32'(len0), 0);
    chk("clear_len1", 32'(len1), 0);
    cyc('0, 2'b00, 2'b01, 1'b0);
    after_edge();
    chk("empty_play_state", 32'(state_o), 0);

    // Playback of {q} with a live key pressed.
    cyc('0, 2'b01, 2'b00, 1'b0);
    cyc(KQ, 2'b00, 2'b00, 1'b0);
    idle(1);
    cyc('0, 2'b01, 2'b00, 1'b0);
    cyc('0, 2'b00, 2'b01, 1'b0);
    cyc(KI, 2'b00, 2'b00, 1'b0);
    after_edge();
`ifdef LIVE_MIX_EN
    chk("live_mix_note", 32'(note_out), 32'(KQ | KI));
`else
    chk("live_mix_note", 32'(note_out), 32'(KQ));
`endif
    idle(6);

    // Randomized traffic.
    last_n = '0;
    for (int i = 0; i < 900; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) n = '0;
      else if (r < 8) n = NW'(1) << $urandom_range(0, NW - 1);
      else if (r == 8) n = last_n;
      else n = NW'($urandom);
      last_n = n;
      cyc(n,
          ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
          ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
          $urandom_range(0, 99) == 0);
    end

    // Asynchronous reset in the middle of playback.
    cyc('0, 2'b00, 2'b00, 1'b1);
    cyc('0, 2'b01, 2'b00, 1'b0);
    cyc(KW, 2'b00, 2'b00, 1'b0);
    idle(1);
    cyc(KO, 2'b00, 2'b00, 1'b0);
    idle(1);
    cyc('0, 2'b01, 2'b00, 1'b0);
    cyc('0, 2'b00, 2'b01, 1'b0);
    idle(3);
    @(negedge clk);
    #2;
    chk("pre_reset_note", 32'(note_out), 32'(KW));
    reset = 1'b0;
    #1;
    chk("async_reset_note", 32'(note_out), 0);
    chk("async_reset_state", 32'(state_o), 0);
    chk("async_reset_len0", 32'(len0), 0);
    chk("async_reset_len1", 32'(len1), 0);
    model_reset();
    @(negedge clk);
    #2 reset = 1'b1;

    cyc(KE, 2'b00, 2'b00, 1'b0);
    idle(3);
    @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left unchecked", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_scheduler.md
Name: sample_scheduler

Overview:
Record/playback controller for the two-track note sampler. Accepts one-hot note levels from the keyboard tracker and records up to STEPS notes per track. Plays one or both tracks back at a fixed step rate and arbitrates the single 9-bit note output between live input, recording, and playback. Sits between keyboard_tracker and the LED/audio note sink. Replaces the ad-hoc KEY/SW sequencing logic with a single-clock FSM.

Parameters:
NOTE_W, 9, note vector width (one bit per key q..o)
STEPS, 10, max notes stored per track
TICK_DIV, 12500000, clk cycles each playback step is held (4 Hz at 50 MHz)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
note_in  in  NOTE_W  live key levels from keyboard tracker
rec_req  in  2  one-cycle pulse per track: start/stop recording track k
play_req  in  2  one-cycle pulse per track: start playback of track k
clear  in  1  one-cycle pulse: abort activity and erase both tracks
note_out  out  NOTE_W  registered note to sink
state_o  out  2  00 IDLE, 01 REC, 10 PLAY
busy  out  1  state_o != IDLE
len0  out  4  stored length of track 0 (0..STEPS)
len1  out  4  stored length of track 1 (0..STEPS)

Behaviour:
- Reset (reset=0, async): state IDLE; note_out=0; len0=len1=0; storage zeroed; tick counter 0; prev_note=0.
- A valid note is a one-hot note_in. A "new press" is a valid note_in that differs from prev_note. prev_note registers note_in every cycle in all states.
- IDLE: note_out <= note_in if valid, else 0 (1-cycle latency).
- IDLE priority, same cycle: clear > rec_req > play_req. rec_req=2'b11 selects track 0.
- rec_req[k] in IDLE: lenk <= 0, rec_trk <= k, go REC. A key held at entry is not captured.
- REC: note_out follows live input as in IDLE. Each new press writes mem[rec_trk][lenk] and increments lenk.
- When lenk reaches STEPS, return to IDLE on the cycle after the capture.
- rec_req[rec_trk] in REC returns to IDLE, keeping the length. Other rec_req/play_req bits in REC are ignored.
- A new press and a stop request in the same cycle: the note is captured, then the FSM goes IDLE.
- play_req in IDLE: the play set is play_req masked by (lenk != 0). An empty set stays IDLE. Otherwise go PLAY with step=0 and tick=0.
- PLAY:
  - note_out <= OR over active tracks of mem[k][step], or 0 for a track whose step >= lenk.
  - First note appears the cycle after entry. Each step is held exactly TICK_DIV cycles; tick wraps at TICK_DIV-1, then step increments.
  - When step reaches max(active lens), note_out <= 0 and the FSM returns to IDLE.
  - rec_req and play_req are ignored. Live input is ignored unless LIVE_MIX_EN is defined.
- clear in any state: next cycle state IDLE, len0=len1=0, note_out=0. Storage contents need not be zeroed; lengths gate all reads.
- Widths: step and len are 4 bits (clog2(STEPS+1)). The tick counter is clog2(TICK_DIV) bits. No arithmetic overflow is reachable.

Optional Feature:
LIVE_MIX_EN:
- Defined: during PLAY, a valid note_in is ORed into note_out (play along over the sequence).
- Undefined: note_in has no effect on note_out during PLAY. The mixing logic is absent.

Decomposition:
- sampler_pkg holds NOTE_W and STEPS defaults, the state enum (IDLE/REC/PLAY), NOTE_SILENCE=0, and an is_onehot() function.
- Sub-module tick_gen is natural: a TICK_DIV-cycle terminal-count strobe with synchronous restart, used for the playback step timing.

Test Plan (TICK_DIV=4):
- Reset mid-PLAY: assert reset=0 asynchronously -> note_out=0, state_o=00, len0=len1=0 immediately, with no clk edge needed.
- Record track 0: rec_req=01, then presses q, w, o (note_in 100000000, 010000000, 000000001, each separated by 0), then rec_req=01 -> len0=3, state IDLE. A held key across the press, and two keys at once, are not captured.
- Auto-stop: record 11 presses on track 1 -> len1=10, and IDLE the cycle after the 10th press. The 11th press only appears as live note_out.
- Play both: track 0 = {q,w,o}, track 1 = {e}, play_req=11 -> note_out 101000000 for 4 cycles, then 010000000 for 4, then 000000001 for 4, then 0 and IDLE. Total PLAY = 12 cycles.
- Conflicts:
  - rec_req=01 and play_req=10 in the same cycle -> REC on track 0.
  - play_req on an empty track -> stays IDLE.
  - clear during REC -> IDLE with len0=0.
- LIVE_MIX_EN: during playback of q, press i -> note_out=100000010. With the macro undefined -> 100000000.
